// File: rtl/prog_tick_counter.sv
// Prescaled modulo-N up/down counter: an internal divider produces a one-cycle
// enable every DIV clocks, and the count advances (with wrap and tc pulse) on it.
module prog_tick_counter #(
    parameter int WIDTH  = 4,
    parameter int DIV    = 50_000_000,
    parameter int MODULO = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt_out,
    output logic             tick,
    output logic             tc
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("prog_tick_counter: WIDTH must be >= 1");
        end
        if (DIV < 1) begin : g_bad_div
            $error("prog_tick_counter: DIV must be >= 1");
        end
        if (MODULO < 2 || longint'(MODULO) > (longint'(1) << WIDTH)) begin : g_bad_modulo
            $error("prog_tick_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
        end
    endgenerate

    localparam int              DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULO);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             div_at_last;

    assign div_at_last = (div_cnt_q == DIV_LAST);
    assign tick        = en && div_at_last;

    always_comb begin
        div_cnt_d = div_cnt_q;
        cnt_d     = cnt_q;
        tc_d      = 1'b0;

        if (load) begin
            // Out-of-range load values clamp to the top of the count range.
            cnt_d     = ({1'b0, load_val} < MOD_EXT) ? load_val : CNT_LAST;
            div_cnt_d = '0;
        end else if (en) begin
            div_cnt_d = div_at_last ? '0 : div_cnt_q + 1'b1;
            if (div_at_last) begin
                if (!dir) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        tc_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    if (cnt_q == '0) begin
                        cnt_d = CNT_LAST;
                        tc_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            cnt_q     <= '0;
            tc_q      <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            cnt_q     <= cnt_d;
            tc_q      <= tc_d;
        end
    end

    assign cnt_out = cnt_q;
    assign tc      = tc_q;

endmodule

// File: tb/tb_prog_tick_counter.sv
// Drives two counter instances (DIV=4/MODULO=10 and DIV=1/MODULO=16) with shared
// stimulus and compares each cycle against an integer-arithmetic reference.
module tb_prog_tick_counter;

    localparam int NDUT = 2;
    localparam int DIVS [NDUT] = '{4, 1};
    localparam int MODS [NDUT] = '{10, 16};

    logic       clk = 1'b0;
    logic       reset = 1'b0, en = 1'b0, dir = 1'b0, load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] cnt_a, cnt_b;
    logic       tick_a, tick_b, tc_a, tc_b;

    int n_chk = 0;
    int n_fail = 0;

    // Reference state: count value, enabled cycles into the current period, tc.
    int m_cnt   [NDUT];
    int m_phase [NDUT];
    int m_tc    [NDUT];
    bit m_valid = 1'b0;

    always #5 clk = ~clk;

    prog_tick_counter #(.WIDTH(4), .DIV(4), .MODULO(10)) dut_a (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .cnt_out(cnt_a), .tick(tick_a), .tc(tc_a)
    );

    prog_tick_counter #(.WIDTH(4), .DIV(1), .MODULO(16)) dut_b (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .cnt_out(cnt_b), .tick(tick_b), .tc(tc_b)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dut_cnt(input int k);
        return (k == 0) ? int'(cnt_a) : int'(cnt_b);
    endfunction
    function automatic int dut_tick(input int k);
        return (k == 0) ? int'(tick_a) : int'(tick_b);
    endfunction
    function automatic int dut_tc(input int k);
        return (k == 0) ? int'(tc_a) : int'(tc_b);
    endfunction

    // One clock cycle: apply inputs, compare at the falling edge, advance the
    // reference across the rising edge.
    task automatic step(input bit r, input bit e, input bit d, input bit l, input int lv);
        bit mtick;
        reset = r; en = e; dir = d; load = l; load_val = 4'(lv);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            mtick = e && (m_phase[k] == DIVS[k] - 1);
            if (m_valid) begin
                check($sformatf("cnt[%0d]", k), dut_cnt(k), m_cnt[k]);
                check($sformatf("tc[%0d]", k), dut_tc(k), m_tc[k]);
                check($sformatf("tick[%0d]", k), dut_tick(k), int'(mtick));
            end
            if (r) begin
                m_cnt[k] = 0; m_phase[k] = 0; m_tc[k] = 0;
            end else if (l) begin
                m_cnt[k] = (lv < MODS[k]) ? lv : MODS[k] - 1;
                m_phase[k] = 0; m_tc[k] = 0;
            end else if (e) begin
                m_phase[k] = (m_phase[k] + 1) % DIVS[k];
                m_tc[k] = 0;
                if (mtick) begin
                    if (!d) begin
                        m_tc[k]  = (m_cnt[k] == MODS[k] - 1);
                        m_cnt[k] = (m_cnt[k] + 1) % MODS[k];
                    end else begin
                        m_tc[k]  = (m_cnt[k] == 0);
                        m_cnt[k] = (m_cnt[k] + MODS[k] - 1) % MODS[k];
                    end
                end
            end else begin
                m_tc[k] = 0;
            end
        end
        if (r) m_valid = 1'b1;
        @(posedge clk);
        #1;
        $display("cyc rst=%0b en=%0b dir=%0b ld=%0b lv=%0d | A cnt=%0d tc=%0b | B cnt=%0d tc=%0b",
                 r, e, d, l, lv, cnt_a, tc_a, cnt_b, tc_b);
    endtask

    initial begin
        bit rd;
        @(posedge clk);
        #1;

        // Up count: reset, then 41 enabled cycles.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("reset_cnt", int'(cnt_a), 0);
        check("reset_tc", int'(tc_a), 0);
        for (int i = 1; i <= 41; i++) begin
            step(0, 1, 0, 0, 0);
            if (i == 4)  check("up_first_tick", int'(cnt_a), 1);
            if (i == 15) check("fast_at_15", int'(cnt_b), 15);
            if (i == 16) begin
                check("fast_wrap_cnt", int'(cnt_b), 0);
                check("fast_wrap_tc", int'(tc_b), 1);
            end
            if (i == 17) check("fast_tc_drop", int'(tc_b), 0);
            if (i == 39) check("up_at_9", int'(cnt_a), 9);
            if (i == 40) begin
                check("up_wrap_cnt", int'(cnt_a), 0);
                check("up_wrap_tc", int'(tc_a), 1);
            end
            if (i == 41) check("up_tc_drop", int'(tc_a), 0);
        end

        // Down wrap, then a direction flip just before a tick.
        step(1, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 1, 0, 0);
            if (i == 4) begin
                check("down_wrap_cnt", int'(cnt_a), 9);
                check("down_wrap_tc", int'(tc_a), 1);
            end
        end
        check("down_8", int'(cnt_a), 8);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check("dir_flip_inc", int'(cnt_a), 9);
        check("dir_flip_tc", int'(tc_a), 0);

        // Pause mid-period; the remaining two enabled cycles complete it.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0);
        check("pause_frozen", int'(cnt_a), 0);
        step(0, 1, 0, 0, 0);
        check("resume_1", int'(cnt_a), 0);
        step(0, 1, 0, 0, 0);
        check("resume_tick", int'(cnt_a), 1);

        // Load on a tick edge suppresses the tick; out-of-range loads clamp.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 7);
        check("load_val", int'(cnt_a), 7);
        check("load_tc", int'(tc_a), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        check("load_hold", int'(cnt_a), 7);
        step(0, 1, 0, 0, 0);
        check("load_next_tick", int'(cnt_a), 8);
        step(0, 1, 0, 1, 15);
        check("load_clamp", int'(cnt_a), 9);
        check("load_noclamp_b", int'(cnt_b), 15);

        // Reset beats load on a would-be wrap edge.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        step(1, 1, 0, 1, 5);
        check("rst_prio_cnt", int'(cnt_a), 0);
        check("rst_prio_tc", int'(tc_a), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        check("rst_prio_hold", int'(cnt_a), 0);
        step(0, 1, 0, 0, 0);
        check("rst_prio_tick", int'(cnt_a), 1);

        // Randomized traffic against the reference.
        rd = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(9) == 0) rd = ~rd;
            step($urandom_range(199) == 0, $urandom_range(3) != 0, rd,
                 $urandom_range(29) == 0, int'($urandom_range(15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_tick_counter.md
# prog_tick_counter

Parametrised single-clock counter with an integrated prescaler: an internal divider produces a one-cycle enable `tick` every `DIV` clock cycles, and a modulo-`MODULO` up/down counter advances on each tick. It replaces the divided-clock-plus-counter arrangement in the lab tops. Everything runs on the oscillator clock, with no derived clocks. Typical use is a seconds/digit counter feeding display logic; `tc` cascades to the next digit's `en`.

## Interface

**Parameters**
- `WIDTH`, default 4: counter output width.
- `DIV`, default 50_000_000: prescaler ratio in clk cycles per tick. Must be ≥1.
- `MODULO`, default 16: count range is 0..MODULO-1. Must satisfy 2 ≤ MODULO ≤ 2^WIDTH.
- Parameter violations must fail at elaboration.

**Ports**
- `clk`, input, 1: oscillator clock. Sole clock; all logic is on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `en`, input, 1: count enable. Low pauses the prescaler and the counter.
- `dir`, input, 1: 0 counts up, 1 counts down. Sampled at tick edges.
- `load`, input, 1: synchronous parallel load.
- `load_val`, input, WIDTH: load value.
- `cnt_out`, output, WIDTH: registered count value.
- `tick`, output, 1: combinational, equal to `en && div_cnt == DIV-1`. The counter advances on the edge where `tick` is 1.
- `tc`, output, 1: registered terminal-count pulse.

## Operation

**Prescaler**
- `div_cnt` is internal, $clog2(DIV) bits (minimum 1).
- When `en`=1 it increments each cycle, running 0..DIV-1 and then returning to 0.
- When `en`=0 it holds.
- With DIV=1, `tick` equals `en`.

**Counter on a tick edge, up (`dir`=0)**
- At MODULO-1, the next value is 0 (wrap).
- Otherwise the next value is cnt+1.

**Counter on a tick edge, down (`dir`=1)**
- At 0, the next value is MODULO-1 (wrap).
- Otherwise the next value is cnt-1.

**Priority per edge (highest first)**
- `reset`: `cnt_out`=0, `div_cnt`=0, `tc`=0.
- `load`:
  - `cnt_out` = `load_val` if `load_val` < MODULO, else MODULO-1 (clamp).
  - `div_cnt` = 0.
  - `tc` = 0.
  - Applies regardless of `en`, and suppresses a coincident tick.
- `tick`: count update as above.
- Otherwise: hold.

**Terminal count**
- `tc` is 1 for exactly one clk cycle: the cycle immediately after an edge on which a tick caused a wrap.
- It is therefore high while `cnt_out` shows the wrapped value (0 for up, MODULO-1 for down).
- `tc` is never asserted by a load or by reset.

**Direction changes**
- A `dir` change between ticks has no effect until the next tick edge.
- No prescaler disturbance.

**Pausing**
- `en` dropping mid-period freezes `div_cnt`.
- On resume, the tick arrives after the remaining DIV-1-div_cnt enabled cycles. The partial period is not restarted.

## Timing

- **Reset values:** `cnt_out`=0, `tc`=0. `tick`=0 out of reset (because `div_cnt`=0) unless DIV=1 and `en`=1.
- **Tick period:** first tick after reset/load with `en` held high occurs on the DIV-th rising edge after the edge releasing reset/load. Ticks then recur every DIV cycles.
- **Counter latency:** `cnt_out` changes on the same edge where `tick`=1. New value is visible the following cycle.
- **`tc` latency:** rises on the same edge that writes the wrapped value and falls on the next edge.
- **Cascading:** `tc` feeding the next stage's `en` with DIV=1 yields one increment per wrap.
- **Load latency:** 1 cycle. `cnt_out` shows the loaded/clamped value the cycle after `load`=1.
- **Reset mid-period:** reset overrides `load` and `tick` on the same edge. Prescaler phase is lost.

## Test plan

Bench parameters: WIDTH=4, DIV=4, MODULO=10, unless stated otherwise.

1. **Up count:** reset 2 cycles, then `en`=1, `dir`=0 → `cnt_out` steps 0,1,…,9,0 every 4 clk. `tc`=1 for exactly one cycle when `cnt_out` becomes 0, after 40 clk.
2. **Down wrap:** reset, `dir`=1, `en`=1 → first tick gives `cnt_out`=9 with a `tc` pulse, then 8,7,… every 4 clk. Flip `dir` to 0 one cycle before a tick → that tick increments.
3. **Pause:** `en`=1 for 2 cycles (`div_cnt`=2), then `en`=0 for 7 cycles → `cnt_out` and `div_cnt` frozen, `tick`=0. Restore `en` → tick after exactly 2 more cycles.
4. **Load:**
   - `load`=1, `load_val`=7 on a tick edge → `cnt_out`=7 with no increment and `tc`=0. Next tick is 4 cycles later, giving 8.
   - `load_val`=15 → `cnt_out`=9, clamped.
5. **Reset priority:** assert `reset` together with `load`=1, `load_val`=5, on a wrap edge → `cnt_out`=0, `tc`=0, and the next tick is 4 cycles after reset release.
6. **Fast mode:** DIV=1, MODULO=16 → `cnt_out` increments every enabled cycle, 15→0 with a one-cycle `tc`, and `tick` tracks `en` exactly.
